// File: rtl/multi_channel_control_if.sv
// Host-side register strobes and per-channel motor control outputs
// for multi_channel_control, grouped into one bundle.
interface multi_channel_control_if #(
    parameter int NCHAN = 3
);
    logic [NCHAN-1:0] cfgld;
    logic             ctrlld;
    logic             wdogdivld;
    logic             tst;
    logic             wdogdis;
    logic             wdreset;
    logic [7:0]       wrtdata;
    logic [NCHAN-1:0] pwmcntce;
    logic [NCHAN-1:0] filterce;
    logic [NCHAN-1:0] invphase;
    logic [NCHAN-1:0] invertpwm;
    logic [NCHAN-1:0] run;
    logic             motorenaint;
    logic             wdwarn;
    logic             ledalive;
    logic [7:0]       controlrdata;
    logic [7:0]       hwconfig;

    modport master (
        output cfgld, ctrlld, wdogdivld, tst, wdogdis, wdreset, wrtdata,
        input  pwmcntce, filterce, invphase, invertpwm, run,
        input  motorenaint, wdwarn, ledalive, controlrdata, hwconfig
    );

    modport slave (
        input  cfgld, ctrlld, wdogdivld, tst, wdogdis, wdreset, wrtdata,
        output pwmcntce, filterce, invphase, invertpwm, run,
        output motorenaint, wdwarn, ledalive, controlrdata, hwconfig
    );
endinterface

// File: rtl/multi_channel_control.sv
// Multi-channel motor control: clock-enable prescalers, per-channel
// PWM/filter dividers, control register, watchdog and heartbeat.
module multi_channel_control #(
    parameter int NCHAN      = 3,
    parameter int PRESCALE   = 64,
    parameter int WDPRESCALE = 256
) (
    input  logic                    clk,
    input  logic                    rstn,
    multi_channel_control_if.slave  bus
);
    localparam int PW = $clog2(PRESCALE);
    localparam int WW = $clog2(WDPRESCALE);

    logic [PW-1:0]    pcnt;
    logic [WW-1:0]    scnt;
    logic             ce64;
    logic             ce16k;
    logic [NCHAN-1:0] run_q;
    logic             men_q;
    logic             wdtrip;
    logic             warn_q;
    logic             menint;
    logic [7:0]       dreg;
    logic [7:0]       wdcnt;
    logic [1:0]       sync;
    logic             wdds;
    logic             wdsel;
    logic             counting;
    logic             trip_clr;
    logic [9:0]       lcnt;
    logic [3:0]       run4;

    // Exponent k -> mask with the low k bits set
    function automatic logic [6:0] low_mask(input logic [2:0] k);
        return 7'h7F >> (3'd7 - k);
    endfunction

    assign ce64  = &pcnt;
    assign ce16k = ce64 & (&scnt);

    // Free-running prescalers producing the base and slow enables
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pcnt <= '0;
            scnt <= '0;
        end else begin
            pcnt <= pcnt + 1'b1;
            if (ce64) scnt <= scnt + 1'b1;
        end
    end

    for (genvar n = 0; n < NCHAN; n++) begin : g_ch
        logic [7:0] cfg;
        logic [6:0] pc;
        logic [6:0] fc;
        logic [6:0] pm;
        logic [6:0] fm;

        assign pm = low_mask(cfg[2:0]);
        assign fm = low_mask(cfg[5:3]);

        // Config is frozen while the motor is enabled; dividers never clear
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                cfg <= '0;
                pc  <= '0;
                fc  <= '0;
            end else begin
                pc <= pc + 1'b1;
                if (ce64) fc <= fc + 1'b1;
                if (bus.cfgld[n] && !menint) cfg <= bus.wrtdata;
            end
        end

        assign bus.pwmcntce[n]  = rstn & ((pc & pm) == pm);
        assign bus.filterce[n]  = ce64 & ((fc & fm) == fm);
        assign bus.invertpwm[n] = cfg[6];
        assign bus.invphase[n]  = cfg[7];
    end

    assign trip_clr = bus.ctrlld && (bus.wrtdata == 8'h80);
    assign menint   = men_q & ~wdtrip;

    // Control register; a trip latches until the host writes motor-off
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            run_q  <= '0;
            men_q  <= 1'b0;
            wdtrip <= 1'b0;
        end else begin
            if (bus.ctrlld) begin
                run_q <= bus.wrtdata[NCHAN-1:0];
                men_q <= bus.wrtdata[6];
            end
            if (trip_clr) wdtrip <= 1'b0;
            else if (counting && wdsel && wdcnt == dreg) wdtrip <= 1'b1;
        end
    end

    assign wdds     = sync[1];
    assign wdsel    = bus.tst ? ce64 : ce16k;
    assign counting = menint & ~bus.wdreset & ~wdds & (dreg != 8'd0);

    // Watchdog: divisor, disable synchroniser, saturating counter, warning
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync   <= '0;
            dreg   <= '0;
            wdcnt  <= '0;
            warn_q <= 1'b0;
        end else begin
            sync <= {sync[0], bus.wdogdis};
            if (bus.wdogdivld && !menint) dreg <= bus.wrtdata;
            if (!counting) begin
                wdcnt  <= '0;
                warn_q <= 1'b0;
            end else begin
                if (wdsel && wdcnt != dreg) wdcnt <= wdcnt + 1'b1;
                if (dreg >= 8'd2 && wdcnt >= (dreg >> 1)) warn_q <= 1'b1;
            end
        end
    end

    // Heartbeat counter on the slow enable
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) lcnt <= '0;
        else if (ce16k) lcnt <= lcnt + 1'b1;
    end

    // Zero-pad the run bits to the 4-bit readback field
    always_comb begin
        run4 = '0;
        run4[NCHAN-1:0] = run_q;
    end

    assign bus.run          = run_q;
    assign bus.motorenaint  = menint;
    assign bus.wdwarn       = warn_q;
    assign bus.ledalive     = lcnt[9];
    assign bus.controlrdata = {wdtrip, warn_q, menint, wdds, run4};
    assign bus.hwconfig     = {1'b1, 3'(NCHAN), 4'b0000};
endmodule

// File: tb/tb_multi_channel_control.sv
// Scoreboard bench for multi_channel_control: stimulus queues expected
// values, a negedge monitor pops and compares them.
module tb_multi_channel_control;
    typedef enum int {
        S_PWM, S_FLT, S_RD, S_MEN, S_WARN, S_TRIP,
        S_LED, S_HW, S_INV, S_INVP, S_RUN
    } sel_t;

    typedef struct {
        string      name;
        sel_t       sel;
        logic [7:0] exp;
    } chk_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    chk_t q[$];

    multi_channel_control_if #(.NCHAN(3)) bus ();

    multi_channel_control #(
        .NCHAN(3), .PRESCALE(64), .WDPRESCALE(256)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) cyc <= 0;
        else cyc <= cyc + 1;
    end

    function automatic logic [7:0] sample(sel_t s);
        case (s)
            S_PWM:  return 8'(bus.pwmcntce);
            S_FLT:  return 8'(bus.filterce);
            S_RD:   return bus.controlrdata;
            S_MEN:  return 8'(bus.motorenaint);
            S_WARN: return 8'(bus.wdwarn);
            S_TRIP: return 8'(bus.controlrdata[7]);
            S_LED:  return 8'(bus.ledalive);
            S_HW:   return bus.hwconfig;
            S_INV:  return 8'(bus.invertpwm);
            S_INVP: return 8'(bus.invphase);
            S_RUN:  return 8'(bus.run);
            default: return 8'h00;
        endcase
    endfunction

    always @(negedge clk) begin
        while (q.size() > 0) begin
            chk_t c;
            logic [7:0] act;
            c   = q.pop_front();
            act = sample(c.sel);
            checks++;
            if (act !== c.exp) begin
                errors++;
                $display("FAIL %s at cyc %0d: got %02h want %02h",
                         c.name, cyc, act, c.exp);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string nm, sel_t s, logic [7:0] e);
        chk_t c;
        c.name = nm;
        c.sel  = s;
        c.exp  = e;
        q.push_back(c);
    endtask

    task automatic wr_ctrl(logic [7:0] v);
        bus.ctrlld  = 1'b1;
        bus.wrtdata = v;
        tick();
        bus.ctrlld  = 1'b0;
    endtask

    task automatic wr_cfg(int n, logic [7:0] v);
        bus.cfgld   = 3'(1 << n);
        bus.wrtdata = v;
        tick();
        bus.cfgld   = '0;
    endtask

    task automatic wr_div(logic [7:0] v);
        bus.wdogdivld = 1'b1;
        bus.wrtdata   = v;
        tick();
        bus.wdogdivld = 1'b0;
    endtask

    task automatic wait_to(int t);
        int g;
        g = 0;
        while (cyc != t && g < 5000) begin
            tick();
            g++;
        end
        if (cyc != t) begin
            checks++;
            errors++;
            $display("FAIL wait_to: cyc %0d want %0d", cyc, t);
        end
    endtask

    // Enable motor (0x47) so that the load lands on a cycle == 10 mod 64;
    // e1 is the edge that takes the first watchdog ce64
    task automatic arm(output int e1);
        while (cyc % 64 != 9) tick();
        wr_ctrl(8'h47);
        e1 = cyc - 10 + 64;
    endtask

    task automatic after_reset_checks();
        tick();
        chk("rst_pwm", S_PWM, 8'h07);
        chk("rst_flt", S_FLT, 8'h00);
        chk("rst_rd", S_RD, 8'h00);
        wait_to(62);
        chk("flt_pre", S_FLT, 8'h00);
        tick();
        chk("flt_first", S_FLT, 8'h07);
        tick();
        chk("flt_post", S_FLT, 8'h00);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        int e1;
        logic [2:0] e;
        bus.cfgld     = '0;
        bus.ctrlld    = 1'b0;
        bus.wdogdivld = 1'b0;
        bus.tst       = 1'b0;
        bus.wdogdis   = 1'b0;
        bus.wdreset   = 1'b0;
        bus.wrtdata   = 8'h00;

        repeat (3) tick();
        chk("res_pwm", S_PWM, 8'h00);
        chk("res_flt", S_FLT, 8'h00);
        chk("res_rd", S_RD, 8'h00);
        chk("res_men", S_MEN, 8'h00);
        chk("res_led", S_LED, 8'h00);
        chk("res_run", S_RUN, 8'h00);
        chk("hwconfig", S_HW, 8'hB0);
        tick();
        rstn = 1'b1;
        after_reset_checks();

        wr_cfg(0, 8'h03);
        wr_cfg(2, 8'hC0);
        chk("invpwm", S_INV, 8'h04);
        chk("invph", S_INVP, 8'h04);
        for (int i = 0; i < 16; i++) begin
            tick();
            e = 3'b110 | ((cyc % 8 == 7) ? 3'b001 : 3'b000);
            chk("pwm_div8", S_PWM, 8'(e));
        end

        wr_cfg(0, 8'h08);
        chk("pwm_p0", S_PWM, 8'h07);
        for (int i = 0; i < 260; i++) begin
            tick();
            e = 3'b000;
            if (cyc % 64 == 63)
                e = 3'b110 | (((cyc / 64) % 2 == 1) ? 3'b001 : 3'b000);
            chk("flt_div2", S_FLT, 8'(e));
        end

        wr_div(8'd4);
        bus.tst = 1'b1;
        chk("wd_idle", S_RD, 8'h00);
        arm(e1);
        chk("wd_armed", S_RD, 8'h27);
        wait_to(e1 + 64);
        chk("warn_early", S_WARN, 8'h00);
        tick();
        chk("warn_set", S_WARN, 8'h01);
        chk("rd_warn", S_RD, 8'h67);
        wait_to(e1 + 255);
        chk("pre_trip", S_RD, 8'h67);
        tick();
        chk("trip_rd", S_RD, 8'hC7);
        chk("trip_men", S_MEN, 8'h00);
        tick();
        chk("trip_rd2", S_RD, 8'h87);

        wr_ctrl(8'h40);
        chk("w40_men", S_MEN, 8'h00);
        chk("w40_rd", S_RD, 8'h80);
        wr_ctrl(8'h80);
        chk("w80_rd", S_RD, 8'h00);
        wr_ctrl(8'h47);
        chk("w47_men", S_MEN, 8'h01);
        chk("w47_rd", S_RD, 8'h27);

        wr_cfg(1, 8'hFF);
        chk("lock_inv", S_INV, 8'h04);
        chk("lock_invp", S_INVP, 8'h04);
        chk("lock_pwm", S_PWM, 8'h07);
        wr_div(8'd1);
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 3; j++) begin
                tick();
                while (cyc % 64 != 0) tick();
            end
            bus.wdreset = 1'b1;
            tick();
            bus.wdreset = 1'b0;
            chk("kick_trip", S_TRIP, 8'h00);
            chk("kick_men", S_MEN, 8'h01);
        end

        bus.wdogdis = 1'b1;
        tick();
        chk("wdds_1clk", S_RD, 8'h27);
        tick();
        chk("wdds_2clk", S_RD, 8'h37);
        repeat (6 * 64) tick();
        chk("dis_trip", S_RD, 8'h37);
        bus.wdogdis = 1'b0;
        repeat (2) tick();
        chk("dis_off", S_RD, 8'h27);

        wr_ctrl(8'h00);
        arm(e1);
        wait_to(e1 + 255);
        wr_ctrl(8'h80);
        chk("clr_win_trip", S_TRIP, 8'h00);
        chk("clr_win_rd", S_RD, 8'h40);
        tick();
        chk("clr_win_rd2", S_RD, 8'h00);

        arm(e1);
        wait_to(e1 + 64 + 5);
        chk("mid_rd", S_RD, 8'h67);
        tick();
        rstn = 1'b0;
        #1;
        chk("ar_pwm", S_PWM, 8'h00);
        chk("ar_flt", S_FLT, 8'h00);
        chk("ar_rd", S_RD, 8'h00);
        chk("ar_men", S_MEN, 8'h00);
        chk("ar_warn", S_WARN, 8'h00);
        chk("ar_run", S_RUN, 8'h00);
        chk("ar_inv", S_INV, 8'h00);
        chk("ar_invp", S_INVP, 8'h00);
        chk("ar_led", S_LED, 8'h00);
        repeat (2) tick();
        rstn = 1'b1;
        after_reset_checks();
        chk("end_hw", S_HW, 8'hB0);

        repeat (2) tick();
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d checks left unconsumed", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
